adder_4bit_dff: RTL and testbench

- Registered 4-bit add-with-enable datapath slice.
- A combinational 4-bit adder (AA + BB, gated by EN) feeds a bank of write-enabled D flip-flops.
- The cache-fill controller uses it for its word counter (increment by 1) and its block-offset address (increment by 2). The register advances only on a valid memory return.
- Built structurally from full-adder cells and single-bit flops with write enable.

---
 rtl/adder_4bit_dff.sv | 94 +++++++++
 tb/tb_adder_4bit_dff.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_4bit_dff.sv
// rtl/adder_4bit_dff.sv - registered 4-bit add-with-enable slice (ripple full adders into write-enabled flops)
// Used as the cache-fill word counter / block-offset register; AA is normally fed back from Q.

module adder_4bit_dff_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module adder_4bit_dff_dffe (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    input  logic i_we,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

module adder_4bit_dff (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] AA,
    input  logic [3:0] BB,
    input  logic       EN,
    input  logic       wen,
    output logic [3:0] SS,
    output logic       CC,
    output logic [3:0] Q,
    output logic       QC
);
    logic [3:0] w_b;
    logic [4:0] w_c;
    logic [3:0] w_s;
    logic [3:0] w_q;
    logic       w_qc;

    // Gating BB (not the sum) makes EN=0 a pure pass-through of AA with no carry.
    assign w_b    = BB & {4{EN}};
    assign w_c[0] = 1'b0;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_bit
            adder_4bit_dff_fa u_fa (
                .i_a (AA[g]),
                .i_b (w_b[g]),
                .i_c (w_c[g]),
                .o_s (w_s[g]),
                .o_c (w_c[g+1])
            );

            adder_4bit_dff_dffe u_q (
                .clk  (clk),
                .rst  (rst),
                .i_d  (w_s[g]),
                .i_we (wen),
                .o_q  (w_q[g])
            );
        end
    endgenerate

    // Carry flop is rewritten on every write, so it flags only the most recent wrap.
    adder_4bit_dff_dffe u_qc (
        .clk  (clk),
        .rst  (rst),
        .i_d  (w_c[4]),
        .i_we (wen),
        .o_q  (w_qc)
    );

    assign SS = w_s;
    assign CC = w_c[4];
    assign Q  = w_q;
    assign QC = w_qc;
endmodule

// File: tb/tb_adder_4bit_dff.sv
// tb/tb_adder_4bit_dff.sv - self-checking bench for adder_4bit_dff against an arithmetic reference model

module tb_adder_4bit_dff;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] AA  = 4'h0;
    logic [3:0] BB  = 4'h0;
    logic       EN  = 1'b0;
    logic       wen = 1'b0;
    logic [3:0] SS;
    logic       CC;
    logic [3:0] Q;
    logic       QC;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_qc   = 0;

    adder_4bit_dff dut (
        .clk (clk),
        .rst (rst),
        .AA  (AA),
        .BB  (BB),
        .EN  (EN),
        .wen (wen),
        .SS  (SS),
        .CC  (CC),
        .Q   (Q),
        .QC  (QC)
    );

    always #5 clk = ~clk;

    function automatic int model_sum(input int a, input int b, input bit en);
        return en ? (a + b) : a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference register state: plain integer arithmetic, reset wins over clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q  = 0;
            m_qc = 0;
        end else if (wen) begin
            m_q  = model_sum(AA, BB, EN) % 16;
            m_qc = model_sum(AA, BB, EN) / 16;
        end
    end

    always @(negedge clk) begin
        chk("cmp_ss", SS, model_sum(AA, BB, EN) % 16);
        chk("cmp_cc", CC, model_sum(AA, BB, EN) / 16);
        chk("cmp_q",  Q,  m_q);
        chk("cmp_qc", QC, m_qc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        AA = v; BB = 4'h0; EN = 1'b0; wen = 1'b1;
        tick();
    endtask

    initial begin
        // 1. reset held with live inputs
        AA = 4'h7; BB = 4'h1; EN = 1'b1; wen = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_q", Q, 0);
            chk("rst_qc", QC, 0);
        end
        chk("rst_ss", SS, 8);
        chk("rst_cc", CC, 0);

        // 2. count by 1 with wrap at edge 16
        rst = 1'b0;
        AA = 4'h0; BB = 4'h1; EN = 1'b1; wen = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("cnt1_q", Q, k % 16);
            chk("cnt1_q3", Q[3], (k >= 8 && k < 16) ? 1 : 0);
            chk("cnt1_qc", QC, (k == 16) ? 1 : 0);
            AA = m_q[3:0];
        end

        // 3. count by 2
        load(4'h0);
        BB = 4'h2; EN = 1'b1; AA = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("cnt2_q", Q, (2 * k) % 16);
            chk("cnt2_qc", QC, (k == 8) ? 1 : 0);
            AA = m_q[3:0];
        end

        // 4. enable gating holds via feedback
        load(4'h5);
        AA = 4'h5; BB = 4'h1; EN = 1'b0; wen = 1'b1;
        repeat (5) begin
            tick();
            chk("en0_ss", SS, 5);
            chk("en0_cc", CC, 0);
            chk("en0_q", Q, 5);
        end
        EN = 1'b1;
        tick();
        chk("en1_q", Q, 6);

        // 5. write-enable hold
        load(4'h3);
        wen = 1'b0; EN = 1'b1; AA = 4'hA; BB = 4'h4;
        #1;
        chk("wen0_ss", SS, 14);
        chk("wen0_cc", CC, 0);
        repeat (3) tick();
        chk("wen0_q", Q, 3);
        wen = 1'b1;
        tick();
        chk("wen1_q", Q, 14);

        // wrap boundary and BB=0 pass-through
        AA = 4'hF; BB = 4'h1; EN = 1'b1; #1;
        chk("wrap_ss", SS, 0);
        chk("wrap_cc", CC, 1);
        tick();
        chk("wrap_q", Q, 0);
        chk("wrap_qc", QC, 1);
        AA = 4'h9; BB = 4'h0; #1;
        chk("bb0_ss", SS, 9);
        chk("bb0_cc", CC, 0);

        // 6. async reset between edges
        load(4'h6);
        AA = 4'h6; BB = 4'h1; EN = 1'b1; wen = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_q", Q, 0);
        chk("arst_qc", QC, 0);
        @(negedge clk);
        rst = 1'b0;
        AA = 4'h0;
        tick();
        chk("arst_restart_q", Q, 1);

        // randomized traffic with occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            AA  = 4'($urandom_range(0, 15));
            BB  = 4'($urandom_range(0, 15));
            EN  = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 24) == 0);
            if (rst == 1'b0 && $urandom_range(0, 1) == 1) AA = m_q[3:0];
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
